// File: rtl/video_test_pattern_gen.sv
// Video timing generator with selectable test patterns: colour bars, checkerboard,
// grey ramp and a checkerboard that scrolls one pixel per frame.
module video_test_pattern_gen #(
    parameter int   H_ACTIVE     = 1280,
    parameter int   H_FRONT      = 110,
    parameter int   H_SYNC       = 40,
    parameter int   H_BACK       = 220,
    parameter int   V_ACTIVE     = 720,
    parameter int   V_FRONT      = 5,
    parameter int   V_SYNC       = 5,
    parameter int   V_BACK       = 20,
    parameter logic HSYNC_POL    = 1'b1,
    parameter logic VSYNC_POL    = 1'b1,
    parameter int   COLOR_WIDTH  = 8,
    parameter int   CHECKER_LOG2 = 5,
    parameter int   BLINK_BIT    = 5
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic [1:0]             mode,
    output logic                   hSync,
    output logic                   vSync,
    output logic                   dataEnable,
    output logic [COLOR_WIDTH-1:0] red,
    output logic [COLOR_WIDTH-1:0] green,
    output logic [COLOR_WIDTH-1:0] blue,
    output logic                   frameStart,
    output logic                   blink
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FRONT + V_SYNC);

    localparam logic [COLOR_WIDTH-1:0] C_ONES = {COLOR_WIDTH{1'b1}};
    localparam logic [COLOR_WIDTH-1:0] C_ZERO = {COLOR_WIDTH{1'b0}};

    // {r,g,b} on/off for each bar: white, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [2:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b111;
            3'd1:    return 3'b110;
            3'd2:    return 3'b011;
            3'd3:    return 3'b010;
            3'd4:    return 3'b101;
            3'd5:    return 3'b100;
            3'd6:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    logic [HW-1:0]          h_cnt_r;
    logic [VW-1:0]          v_cnt_r;
    logic [15:0]            frame_cnt_r;
    logic [1:0]             active_mode_r;
    logic                   de_r, hs_r, vs_r, fs_r, blink_r;
    logic [COLOR_WIDTH-1:0] red_r, green_r, blue_r;

    logic                   h_last_s, v_last_s, first_s, active_s;
    logic                   checker_s, scroll_s;
    logic [1:0]             eff_mode_s;
    logic [2:0]             bar_idx_s, bar_rgb_s;
    logic [COLOR_WIDTH-1:0] red_s, green_s, blue_s;

    assign h_last_s  = (h_cnt_r == H_LAST);
    assign v_last_s  = (v_cnt_r == V_LAST);
    assign first_s   = (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == {VW{1'b0}});
    assign active_s  = (h_cnt_r < H_ACT_END) && (v_cnt_r < V_ACT_END);
    // The first pixel of a frame already uses the mode being latched on it.
    assign eff_mode_s = first_s ? mode : active_mode_r;
    assign checker_s = h_cnt_r[CHECKER_LOG2] ^ v_cnt_r[CHECKER_LOG2];
    // Only bits up to CHECKER_LOG2 of (hCount + frameCount) matter, so the add is kept narrow.
    assign scroll_s  = (|(((CHECKER_LOG2 + 1)'(h_cnt_r) + frame_cnt_r[CHECKER_LOG2:0]) >> CHECKER_LOG2))
                       ^ v_cnt_r[CHECKER_LOG2];
    assign bar_rgb_s = bar_colour(bar_idx_s);

    // Bar index by comparing against elaboration-time thresholds; last bar takes the remainder.
    always_comb begin
        bar_idx_s = 3'd0;
        for (int i = 1; i < 8; i++) begin
            bar_idx_s = (h_cnt_r >= HW'(i * BAR_W)) ? 3'(i) : bar_idx_s;
        end
    end

    // Pixel colour for the current counter position.
    always_comb begin
        red_s   = C_ZERO;
        green_s = C_ZERO;
        blue_s  = C_ZERO;
        if (active_s) begin
            case (eff_mode_s)
                2'd0: begin
                    red_s   = bar_rgb_s[2] ? C_ONES : C_ZERO;
                    green_s = bar_rgb_s[1] ? C_ONES : C_ZERO;
                    blue_s  = bar_rgb_s[0] ? C_ONES : C_ZERO;
                end
                2'd1: begin
                    red_s   = checker_s ? C_ONES : C_ZERO;
                    green_s = checker_s ? C_ONES : C_ZERO;
                    blue_s  = checker_s ? C_ONES : C_ZERO;
                end
                2'd2: begin
                    red_s   = COLOR_WIDTH'(h_cnt_r);
                    green_s = COLOR_WIDTH'(h_cnt_r);
                    blue_s  = COLOR_WIDTH'(h_cnt_r);
                end
                2'd3: begin
                    red_s   = scroll_s ? C_ONES : C_ZERO;
                    green_s = scroll_s ? C_ONES : C_ZERO;
                    blue_s  = scroll_s ? C_ONES : C_ZERO;
                end
                default: begin
                    red_s   = C_ZERO;
                    green_s = C_ZERO;
                    blue_s  = C_ZERO;
                end
            endcase
        end else begin
            red_s   = C_ZERO;
            green_s = C_ZERO;
            blue_s  = C_ZERO;
        end
    end

    // Raster counters, frame counter and per-frame mode latch.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            h_cnt_r       <= {HW{1'b0}};
            v_cnt_r       <= {VW{1'b0}};
            frame_cnt_r   <= 16'd0;
            active_mode_r <= 2'd0;
        end else begin
            if (h_last_s) begin
                h_cnt_r <= {HW{1'b0}};
                v_cnt_r <= v_last_s ? {VW{1'b0}} : v_cnt_r + VW'(1);
            end else begin
                h_cnt_r <= h_cnt_r + HW'(1);
            end
            if (h_last_s && v_last_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
            if (first_s) begin
                active_mode_r <= mode;
            end
        end
    end

    // Output registers: one cycle behind the counters.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            de_r    <= 1'b0;
            hs_r    <= ~HSYNC_POL;
            vs_r    <= ~VSYNC_POL;
            fs_r    <= 1'b0;
            blink_r <= 1'b0;
            red_r   <= C_ZERO;
            green_r <= C_ZERO;
            blue_r  <= C_ZERO;
        end else begin
            de_r    <= active_s;
            hs_r    <= (h_cnt_r >= HS_START && h_cnt_r < HS_END) ? HSYNC_POL : ~HSYNC_POL;
            vs_r    <= (v_cnt_r >= VS_START && v_cnt_r < VS_END) ? VSYNC_POL : ~VSYNC_POL;
            fs_r    <= first_s;
            blink_r <= frame_cnt_r[BLINK_BIT];
            red_r   <= red_s;
            green_r <= green_s;
            blue_r  <= blue_s;
        end
    end

    assign dataEnable = de_r;
    assign hSync      = hs_r;
    assign vSync      = vs_r;
    assign frameStart = fs_r;
    assign blink      = blink_r;
    assign red        = red_r;
    assign green      = green_r;
    assign blue       = blue_r;

endmodule

// File: tb/tb_video_test_pattern_gen.sv
// Scoreboard bench for video_test_pattern_gen: expectations are queued per clock edge
// (counted from reset release) and a negedge monitor compares them against the outputs.
module tb_video_test_pattern_gen;

    localparam int S_DE = 0, S_HS = 1, S_VS = 2, S_FS = 3, S_BL = 4, S_RGB = 5;

    typedef struct {
        int          cyc;
        int          sig;
        logic [11:0] val;
        string       name;
    } exp_t;

    logic       clock;
    logic       resetN;
    logic [1:0] mode;
    logic       hSync, vSync, dataEnable, frameStart, blink;
    logic [3:0] red, green, blue;

    exp_t        q[$];
    int          edge_n;
    int          n_cmp;
    int          n_bad;
    logic [11:0] act;

    video_test_pattern_gen #(
        .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
        .COLOR_WIDTH(4), .CHECKER_LOG2(2), .BLINK_BIT(1)
    ) dut (
        .clock(clock), .resetN(resetN), .mode(mode),
        .hSync(hSync), .vSync(vSync), .dataEnable(dataEnable),
        .red(red), .green(green), .blue(blue),
        .frameStart(frameStart), .blink(blink)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edges since the last reset release; edge 1 presents pixel (0,0).
    always @(posedge clock or negedge resetN) begin
        if (!resetN) edge_n <= 0;
        else         edge_n <= edge_n + 1;
    end

    function automatic logic [11:0] actual(input int sig);
        case (sig)
            S_DE:    return {11'd0, dataEnable};
            S_HS:    return {11'd0, hSync};
            S_VS:    return {11'd0, vSync};
            S_FS:    return {11'd0, frameStart};
            S_BL:    return {11'd0, blink};
            S_RGB:   return {red, green, blue};
            default: return 12'h000;
        endcase
    endfunction

    task automatic ex(input int c, input int s, input logic [11:0] v, input string nm);
        exp_t e;
        e.cyc = c; e.sig = s; e.val = v; e.name = nm;
        q.push_back(e);
    endtask

    task automatic push_reset_vals();
        ex(0, S_DE, 12'h0, "rst_de");  ex(0, S_FS, 12'h0, "rst_fs");
        ex(0, S_BL, 12'h0, "rst_blink"); ex(0, S_RGB, 12'h000, "rst_rgb");
        ex(0, S_HS, 12'h0, "rst_hsync"); ex(0, S_VS, 12'h0, "rst_vsync");
    endtask

    task automatic push_start_seq();
        ex(1, S_FS, 12'h1, "fs_first");   ex(1, S_DE, 12'h1, "de_first");
        ex(1, S_RGB, 12'hFFF, "bar_white"); ex(1, S_BL, 12'h0, "blink_first");
        ex(2, S_FS, 12'h0, "fs_one_cycle");
        ex(3, S_RGB, 12'hFF0, "bar_yellow_a"); ex(4, S_RGB, 12'hFF0, "bar_yellow_b");
        ex(15, S_RGB, 12'h000, "bar_black");  ex(17, S_DE, 12'h0, "de_blank_start");
        ex(19, S_HS, 12'h1, "hsync_first");  ex(24, S_DE, 12'h0, "de_blank_end");
    endtask

    task automatic goto_edge(input int e);
        while (edge_n < e) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Monitor: compare every queued expectation due at this edge.
    always @(negedge clock) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == edge_n) begin
                act = actual(q[i].sig);
                n_cmp++;
                if (act !== q[i].val) begin
                    n_bad++;
                    $display("FAIL %s at edge %0d: got %h, expected %h", q[i].name, edge_n, act, q[i].val);
                end
                q.delete(i);
            end
        end
    end

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        edge_n = 0;
        resetN = 1'b0;
        mode   = 2'd0;

        push_reset_vals();
        push_start_seq();
        // Remaining colour bars of line 0 and the next line
        ex(5, S_RGB, 12'h0FF, "bar_cyan");    ex(7, S_RGB, 12'h0F0, "bar_green");
        ex(9, S_RGB, 12'hF0F, "bar_magenta"); ex(11, S_RGB, 12'hF00, "bar_red");
        ex(13, S_RGB, 12'h00F, "bar_blue");   ex(16, S_DE, 12'h1, "de_last_px");
        ex(16, S_RGB, 12'h000, "bar_last_px");
        ex(25, S_DE, 12'h1, "de_line1");      ex(25, S_RGB, 12'hFFF, "line1_white");
        // Horizontal sync window, two lines
        ex(18, S_HS, 12'h0, "hs_before");  ex(21, S_HS, 12'h1, "hs_last");
        ex(22, S_HS, 12'h0, "hs_after");   ex(42, S_HS, 12'h0, "hs_l1_before");
        ex(43, S_HS, 12'h1, "hs_l1_first"); ex(45, S_HS, 12'h1, "hs_l1_last");
        ex(46, S_HS, 12'h0, "hs_l1_after");
        // Mode switched to 1 at edge 80 (line 3): frame 0 remains bars
        ex(97, S_RGB, 12'hFFF, "midframe_bar_w"); ex(99, S_RGB, 12'hFF0, "midframe_bar_y");
        ex(193, S_DE, 12'h0, "de_vblank");
        ex(216, S_VS, 12'h0, "vs_before");  ex(217, S_VS, 12'h1, "vs_first");
        ex(264, S_VS, 12'h1, "vs_last");    ex(265, S_VS, 12'h0, "vs_after");
        ex(288, S_FS, 12'h0, "fs_pre_f1");  ex(289, S_FS, 12'h1, "fs_f1");
        ex(290, S_FS, 12'h0, "fs_post_f1");
        // Frame 1: checkerboard
        ex(289, S_RGB, 12'h000, "chk_0_0");  ex(293, S_RGB, 12'hFFF, "chk_4_0");
        ex(385, S_RGB, 12'hFFF, "chk_0_4");  ex(389, S_RGB, 12'h000, "chk_4_4");
        ex(289, S_BL, 12'h0, "blink_f1");
        // Frame 2: grey ramp
        ex(577, S_FS, 12'h1, "fs_f2");       ex(577, S_BL, 12'h1, "blink_f2");
        ex(577, S_RGB, 12'h000, "ramp_x0");  ex(582, S_RGB, 12'h555, "ramp_x5");
        ex(592, S_RGB, 12'hFFF, "ramp_x15"); ex(593, S_RGB, 12'h000, "ramp_blank");
        ex(593, S_DE, 12'h0, "ramp_blank_de"); ex(611, S_RGB, 12'hAAA, "ramp_l1_x10");
        // Frames 3..6: scrolling checkerboard
        ex(865, S_BL, 12'h1, "blink_f3");    ex(865, S_RGB, 12'h000, "scr_f3_h0");
        ex(866, S_RGB, 12'hFFF, "scr_f3_h1");
        ex(1153, S_BL, 12'h0, "blink_f4");   ex(1153, S_RGB, 12'hFFF, "scr_f4_h0");
        ex(1157, S_RGB, 12'h000, "scr_f4_h4"); ex(1249, S_RGB, 12'h000, "scr_f4_v4");
        ex(1441, S_BL, 12'h0, "blink_f5");   ex(1441, S_RGB, 12'hFFF, "scr_f5_h0");
        ex(1443, S_RGB, 12'hFFF, "scr_f5_h2"); ex(1444, S_RGB, 12'h000, "scr_f5_h3");
        ex(1729, S_BL, 12'h1, "blink_f6");   ex(1729, S_RGB, 12'hFFF, "scr_f6_h0");
        ex(1730, S_RGB, 12'hFFF, "scr_f6_h1"); ex(1731, S_RGB, 12'h000, "scr_f6_h2");
        ex(2022, S_DE, 12'h1, "pre_rst_de"); ex(2022, S_RGB, 12'hFFF, "pre_rst_rgb");

        repeat (3) @(posedge clock);
        #1 resetN = 1'b1;

        goto_edge(80);   mode = 2'd1;
        goto_edge(400);  mode = 2'd2;
        goto_edge(700);  mode = 2'd3;

        // Mid-line reset with hCount == 7; checked before the next clock edge
        goto_edge(2023);
        push_reset_vals();
        resetN = 1'b0;
        mode   = 2'd0;
        #1;
        n_cmp++;
        if (dataEnable !== 1'b0) begin
            n_bad++;
            $display("FAIL async_rst_de: got %b", dataEnable);
        end
        n_cmp++;
        if (frameStart !== 1'b0) begin
            n_bad++;
            $display("FAIL async_rst_fs: got %b", frameStart);
        end
        n_cmp++;
        if (blink !== 1'b0) begin
            n_bad++;
            $display("FAIL async_rst_blink: got %b", blink);
        end
        n_cmp++;
        if (hSync !== 1'b0) begin
            n_bad++;
            $display("FAIL async_rst_hsync: got %b", hSync);
        end
        n_cmp++;
        if (vSync !== 1'b0) begin
            n_bad++;
            $display("FAIL async_rst_vsync: got %b", vSync);
        end
        n_cmp++;
        if ({red, green, blue} !== 12'h000) begin
            n_bad++;
            $display("FAIL async_rst_rgb: got %h", {red, green, blue});
        end
        @(negedge clock);
        #1;
        push_start_seq();
        repeat (2) @(posedge clock);
        #1 resetN = 1'b1;
        goto_edge(30);
        @(negedge clock);
        #1;

        foreach (q[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s never checked: expected %h at edge %0d", q[i].name, q[i].val, q[i].cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
